// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the per-domain clock-gating controller.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {RUN, OFF, WAKE} dom_state_t;

  localparam int unsigned WAKE_LAT_DEF = 2;
  localparam int unsigned WAKE_CNT_W   = $clog2(WAKE_LAT_DEF + 1);

  function automatic int unsigned wake_cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_dom.sv
// One gated domain: idle counter, RUN/OFF/WAKE sequencer and settle counter.
module clk_gate_ctrl_dom
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              busy,
  input  logic              wake_req,
  output logic              pwr_en,
  output logic              ready_raw,
  output logic              gate_evt
);

  localparam int unsigned WCW = wake_cnt_w(WAKE_LAT);
  localparam logic [31:0] IDLE_MAX = 32'((64'(1) << IDLE_W) - 1);

  dom_state_t        state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W:0]   cnt_inc;
  logic [WCW-1:0]    wake_cnt;
  logic              idle;

  assign idle    = !busy && !wake_req;
  assign cnt_inc = {1'b0, idle_cnt} + {{IDLE_W{1'b0}}, 1'b1};
  // Event decoded combinationally so the top counter updates on the gating edge.
  assign gate_evt = (state == RUN) && idle && (idle_thresh != '0) &&
                    (cnt_inc >= {1'b0, idle_thresh});

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      idle_cnt  <= '0;
      wake_cnt  <= '0;
      pwr_en    <= 1'b1;
      ready_raw <= 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (gate_evt) begin
            state     <= OFF;
            idle_cnt  <= '0;
            pwr_en    <= 1'b0;
            ready_raw <= 1'b0;
          end else if (idle) begin
            idle_cnt <= IDLE_W'(sat_add(32'(idle_cnt), 32'd1, IDLE_MAX));
          end else begin
            idle_cnt <= '0;
          end
        end
        OFF: begin
          idle_cnt <= '0;
          if (!idle) begin
            state    <= WAKE;
            wake_cnt <= '0;
            pwr_en   <= 1'b1;
          end
        end
        WAKE: begin
          idle_cnt <= '0;
          if (wake_cnt == WCW'(WAKE_LAT - 1)) begin
            state     <= RUN;
            ready_raw <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller top: per-domain sequencers, override register, gate statistics.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned N_DOM    = 2,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_LAT = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              gating_override_cfg,
  input  logic [N_DOM-1:0]  busy,
  input  logic [N_DOM-1:0]  wake_req,
  input  logic              stat_clr,
  output logic [N_DOM-1:0]  pwr_en,
  output logic              gating_override,
  output logic [N_DOM-1:0]  ready,
  output logic [CNT_W-1:0]  gate_cnt
);

  localparam logic [31:0] CNT_MAX = 32'((64'(1) << CNT_W) - 1);

  logic [N_DOM-1:0] ready_raw;
  logic [N_DOM-1:0] gate_evt;
  logic [31:0]      evt_sum;

  for (genvar d = 0; d < N_DOM; d++) begin : g_dom
    clk_gate_ctrl_dom #(
      .IDLE_W   (IDLE_W),
      .WAKE_LAT (WAKE_LAT)
    ) u_dom (
      .clk         (clk),
      .reset       (reset),
      .idle_thresh (idle_thresh),
      .busy        (busy[d]),
      .wake_req    (wake_req[d]),
      .pwr_en      (pwr_en[d]),
      .ready_raw   (ready_raw[d]),
      .gate_evt    (gate_evt[d])
    );
  end

  // Both operands are flops, so no input reaches ready combinationally.
  assign ready = ready_raw | {N_DOM{gating_override}};

  always_comb begin
    evt_sum = '0;
    for (int unsigned i = 0; i < N_DOM; i++) begin
      evt_sum = evt_sum + 32'(gate_evt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gating_override <= 1'b0;
      gate_cnt        <= '0;
    end else begin
      gating_override <= gating_override_cfg;
      if (stat_clr) begin
        gate_cnt <= '0;
      end else begin
        gate_cnt <= CNT_W'(sat_add(32'(gate_cnt), evt_sum, CNT_MAX));
      end
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Randomized scoreboard bench for clk_gate_ctrl against a behavioural domain model.
module tb_clk_gate_ctrl;

  localparam int N_DOM    = 2;
  localparam int IDLE_W   = 4;
  localparam int WAKE_LAT = 2;
  localparam int CNT_W    = 3;
  localparam int IDLE_MAX = (1 << IDLE_W) - 1;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
  localparam int N_CYC    = 4000;

  logic              clk = 1'b0;
  logic              reset;
  logic [IDLE_W-1:0] idle_thresh;
  logic              gating_override_cfg;
  logic [N_DOM-1:0]  busy;
  logic [N_DOM-1:0]  wake_req;
  logic              stat_clr;
  logic [N_DOM-1:0]  pwr_en;
  logic              gating_override;
  logic [N_DOM-1:0]  ready;
  logic [CNT_W-1:0]  gate_cnt;

  clk_gate_ctrl #(
    .N_DOM    (N_DOM),
    .IDLE_W   (IDLE_W),
    .WAKE_LAT (WAKE_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .idle_thresh         (idle_thresh),
    .gating_override_cfg (gating_override_cfg),
    .busy                (busy),
    .wake_req            (wake_req),
    .stat_clr            (stat_clr),
    .pwr_en              (pwr_en),
    .gating_override     (gating_override),
    .ready               (ready),
    .gate_cnt            (gate_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_DOM-1:0] pwr;
    logic [N_DOM-1:0] rdy;
    logic             ov;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: consecutive-idle run length, gated flag, remaining settle cycles.
  int idle_run [N_DOM];
  bit gated    [N_DOM];
  int wake_left[N_DOM];
  int m_cnt;
  bit m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(output exp_t e);
    int  events;
    bit  idle;
    events = 0;
    if (reset) begin
      for (int d = 0; d < N_DOM; d++) begin
        idle_run[d] = 0; gated[d] = 0; wake_left[d] = 0;
      end
      m_cnt = 0;
      m_ov  = 0;
    end else begin
      for (int d = 0; d < N_DOM; d++) begin
        idle = !busy[d] && !wake_req[d];
        if (wake_left[d] > 0) begin
          wake_left[d]--;
        end else if (gated[d]) begin
          if (!idle) begin
            gated[d] = 0;
            wake_left[d] = WAKE_LAT;
          end
        end else if (idle) begin
          idle_run[d] = (idle_run[d] + 1 > IDLE_MAX) ? IDLE_MAX : idle_run[d] + 1;
          if (idle_thresh != 0 && idle_run[d] >= int'(idle_thresh)) begin
            gated[d] = 1;
            idle_run[d] = 0;
            events++;
          end
        end else begin
          idle_run[d] = 0;
        end
      end
      if (stat_clr) m_cnt = 0;
      else m_cnt = (m_cnt + events > CNT_MAX) ? CNT_MAX : m_cnt + events;
      m_ov = gating_override_cfg;
    end
    for (int d = 0; d < N_DOM; d++) begin
      e.pwr[d] = !gated[d];
      e.rdy[d] = (!gated[d] && wake_left[d] == 0) || m_ov;
    end
    e.ov  = m_ov;
    e.cnt = CNT_W'(m_cnt);
  endtask

  // Monitor: every edge presents a full output set; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pwr_en", 32'(pwr_en), 32'(e.pwr));
        check("ready", 32'(ready), 32'(e.rdy));
        check("gating_override", 32'(gating_override), 32'(e.ov));
        check("gate_cnt", 32'(gate_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin
    exp_t e;
    int   pb;
    int   rst_left;
    int   ov_left;
    reset = 1'b1;
    idle_thresh = 4'd4;
    gating_override_cfg = 1'b0;
    busy = '0;
    wake_req = '0;
    stat_clr = 1'b0;
    pb = 20;
    rst_left = 3;
    ov_left = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (cyc % 150 == 0) begin
        // New segment: pick threshold (sometimes 0 = gating disabled) and busy density.
        idle_thresh = ($urandom_range(0, 5) == 0) ? '0 : IDLE_W'($urandom_range(1, IDLE_MAX));
        pb = $urandom_range(0, 3) * 20;
      end else if ($urandom_range(0, 199) == 0) begin
        idle_thresh = IDLE_W'($urandom_range(1, IDLE_MAX));
      end
      if (rst_left == 0 && $urandom_range(0, 599) == 0) rst_left = $urandom_range(1, 3);
      reset = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      if (ov_left == 0 && $urandom_range(0, 99) == 0) ov_left = $urandom_range(1, 20);
      gating_override_cfg = (ov_left > 0);
      if (ov_left > 0) ov_left--;
      for (int d = 0; d < N_DOM; d++) begin
        busy[d]     = ($urandom_range(0, 99) < pb);
        wake_req[d] = ($urandom_range(0, 99) < 3);
      end
      stat_clr = ($urandom_range(0, 79) == 0);
      model_step(e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
